// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes,
// ALUop encodings (also consumed by ALUControl) and the FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_FUNC = 4'd5
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11
    } state_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the multicycle MIPS datapath. Outputs are
// decoded from the current state; only the memory-completion enables use MemReady.
import mips_ctrl_pkg::*;

module multicycle_control #(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUop,
    output logic       SignExtend,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;

    always_ff @(posedge CLK) begin
        if (Reset) state <= RESET_STATE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((Opcode == OP_LW) || (Opcode == OP_SW)) next_state = S_MEMADR;
                else if (Opcode == OP_RTYPE)                next_state = S_EXEC;
                else if (Opcode == OP_BEQ)                  next_state = S_BRANCH;
                else if (Opcode == OP_J)                    next_state = S_JUMP;
                else if (is_imm_op(Opcode))                 next_state = S_IMMEXEC;
                else                                        next_state = S_FETCH;
            end
            S_MEMADR:  next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:    next_state = S_RWB;
            S_RWB:     next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            S_IMMEXEC: next_state = S_IMMWB;
            S_IMMWB:   next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    // Reset masks every output combinationally so an abandoned instruction
    // cannot issue a write on the reset cycle itself.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = ALU_ADD;
        SignExtend  = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        InstrDone   = 1'b0;
        IllegalOp   = 1'b0;
        State       = Reset ? RESET_STATE : state;
        if (!Reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    SignExtend = 1'b1;
                    IllegalOp  = !((Opcode == OP_LW) || (Opcode == OP_SW) ||
                                   (Opcode == OP_RTYPE) || (Opcode == OP_BEQ) ||
                                   (Opcode == OP_J) || is_imm_op(Opcode));
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    SignExtend = 1'b1;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite  = 1'b1;
                    MemToReg  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite  = 1'b1;
                    IorD      = 1'b1;
                    InstrDone = MemReady;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUop   = ALU_FUNC;
                end
                S_RWB: begin
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    InstrDone   = 1'b1;
                end
                S_JUMP: begin
                    PCWrite   = 1'b1;
                    PCSource  = 2'b10;
                    InstrDone = 1'b1;
                end
                S_IMMEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    SignExtend = !((Opcode == OP_ANDI) || (Opcode == OP_ORI));
                    if (Opcode == OP_ANDI)      ALUop = ALU_AND;
                    else if (Opcode == OP_ORI)  ALUop = ALU_OR;
                    else if (Opcode == OP_SLTI) ALUop = ALU_SLT;
                    else                        ALUop = ALU_ADD;
                end
                S_IMMWB: begin
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected control traces are planned from
// the instruction's step list and stall counts, then compared cycle by cycle.
import mips_ctrl_pkg::*;

module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB;
    logic [3:0] ALUop, State;
    logic       SignExtend, RegDst, MemToReg, RegWrite, InstrDone, IllegalOp;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .SignExtend(SignExtend), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcw, pcwc;
        logic [1:0] pcs;
        logic       iord, mrd, mwr, irw, srca;
        logic [1:0] srcb;
        logic [3:0] aop;
        logic       sext, rdst, m2r, rw, done, ill;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        logic rdy;
        ctl_t c;
    } step_t;

    step_t plan[$];
    ctl_t  act_q[$];
    int    total = 0;
    int    bad   = 0;

    localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4, K_J = 5, K_IMM = 6;

    function automatic int classify(input logic [5:0] op);
        case (op)
            OP_LW:    return K_LW;
            OP_SW:    return K_SW;
            OP_RTYPE: return K_R;
            OP_BEQ:   return K_BEQ;
            OP_J:     return K_J;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: return K_IMM;
            default:  return K_ILL;
        endcase
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c = '{pcw: PCWrite, pcwc: PCWriteCond, pcs: PCSource, iord: IorD,
              mrd: MemRead, mwr: MemWrite, irw: IRWrite, srca: ALUSrcA,
              srcb: ALUSrcB, aop: ALUop, sext: SignExtend, rdst: RegDst,
              m2r: MemToReg, rw: RegWrite, done: InstrDone, ill: IllegalOp,
              st: State};
        return c;
    endfunction

    task automatic add(input logic rdy, input ctl_t c);
        step_t s;
        s.rdy = rdy;
        s.c   = c;
        plan.push_back(s);
    endtask

    function automatic ctl_t fetch_word(input logic ready);
        ctl_t c;
        c = '0;
        c.st = S_FETCH; c.mrd = 1'b1; c.srcb = 2'b01; c.aop = ALU_ADD;
        c.irw = ready; c.pcw = ready;
        return c;
    endfunction

    // Expected trace of one instruction: fetch (fs stall cycles), decode, then
    // the opcode's own steps; memory steps stall ms cycles.
    task automatic plan_instr(input logic [5:0] op, input int fs, input int ms);
        ctl_t c;
        int   k;
        k = classify(op);
        for (int i = 0; i <= fs; i++) add(i == fs, fetch_word(i == fs));
        c = '0; c.st = S_DECODE; c.srcb = 2'b11; c.aop = ALU_ADD; c.sext = 1'b1;
        c.ill = (k == K_ILL);
        add(1'($urandom_range(0, 1)), c);
        if (k == K_LW || k == K_SW) begin
            c = '0; c.st = S_MEMADR; c.srca = 1'b1; c.srcb = 2'b10; c.aop = ALU_ADD; c.sext = 1'b1;
            add(1'($urandom_range(0, 1)), c);
            for (int i = 0; i <= ms; i++) begin
                c = '0; c.iord = 1'b1;
                if (k == K_LW) begin c.st = S_MEMRD; c.mrd = 1'b1; end
                else begin c.st = S_MEMWR; c.mwr = 1'b1; c.done = (i == ms); end
                add(i == ms, c);
            end
            if (k == K_LW) begin
                c = '0; c.st = S_MEMWB; c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
                add(1'($urandom_range(0, 1)), c);
            end
        end else if (k == K_R) begin
            c = '0; c.st = S_EXEC; c.srca = 1'b1; c.aop = ALU_FUNC;
            add(1'($urandom_range(0, 1)), c);
            c = '0; c.st = S_RWB; c.rw = 1'b1; c.rdst = 1'b1; c.done = 1'b1;
            add(1'($urandom_range(0, 1)), c);
        end else if (k == K_BEQ) begin
            c = '0; c.st = S_BRANCH; c.srca = 1'b1; c.aop = ALU_SUB; c.pcwc = 1'b1;
            c.pcs = 2'b01; c.done = 1'b1;
            add(1'($urandom_range(0, 1)), c);
        end else if (k == K_J) begin
            c = '0; c.st = S_JUMP; c.pcw = 1'b1; c.pcs = 2'b10; c.done = 1'b1;
            add(1'($urandom_range(0, 1)), c);
        end else if (k == K_IMM) begin
            c = '0; c.st = S_IMMEXEC; c.srca = 1'b1; c.srcb = 2'b10;
            c.aop  = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR :
                     (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            c.sext = !(op == OP_ANDI || op == OP_ORI);
            add(1'($urandom_range(0, 1)), c);
            c = '0; c.st = S_IMMWB; c.rw = 1'b1; c.done = 1'b1;
            add(1'($urandom_range(0, 1)), c);
        end
    endtask

    task automatic drive_plan();
        act_q.delete();
        foreach (plan[i]) begin
            MemReady = plan[i].rdy;
            @(negedge CLK);
            act_q.push_back(sample());
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        ctl_t exp;
        exp = '0; exp.st = S_FETCH;
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            Opcode   = 6'($urandom);
            @(negedge CLK);
            total++;
            if (sample() !== exp) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, sample(), exp);
            end
            @(posedge CLK);
            #1;
        end
        Reset = 1'b0;
    endtask

    task automatic test_lw();
        int ndone;
        Opcode = OP_LW;
        plan.delete(); plan_instr(OP_LW, 0, 0);
        drive_plan();
        ndone = 0;
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c) begin
                bad++;
                $display("FAIL lw cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
            if (act_q[i].done) ndone++;
        end
        total++;
        if (ndone != 1 || act_q.size() != 5 || !act_q[4].done) begin
            bad++;
            $display("FAIL lw_done_pulse got=%0d pulses want=1 in cycle 5", ndone);
        end
    endtask

    task automatic test_sw_stall();
        int nwr;
        Opcode = OP_SW;
        plan.delete(); plan_instr(OP_SW, 0, 3);
        drive_plan();
        nwr = 0;
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c) begin
                bad++;
                $display("FAIL sw_stall cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
            if (act_q[i].mwr) nwr++;
        end
        total++;
        if (nwr != 4) begin
            bad++;
            $display("FAIL sw_memwrite_len got=%0d want=4", nwr);
        end
    endtask

    task automatic test_fetch_stall();
        Opcode = OP_RTYPE;
        plan.delete(); plan_instr(OP_RTYPE, 2, 0);
        drive_plan();
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c) begin
                bad++;
                $display("FAIL fetch_stall cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
        end
    endtask

    task automatic test_andi();
        Opcode = OP_ANDI;
        plan.delete(); plan_instr(OP_ANDI, 0, 0);
        drive_plan();
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c) begin
                bad++;
                $display("FAIL andi cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
        end
    endtask

    task automatic test_illegal();
        Opcode = 6'b111111;
        plan.delete(); plan_instr(6'b111111, 0, 0);
        drive_plan();
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c || act_q[i].rw || act_q[i].mwr || (i > 0 && act_q[i].pcw)) begin
                bad++;
                $display("FAIL illegal cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
        end
    endtask

    task automatic test_reset_mid();
        ctl_t exp;
        Opcode = OP_LW;
        plan.delete(); plan_instr(OP_LW, 0, 2);
        while (plan.size() > 4) void'(plan.pop_back());
        drive_plan();
        foreach (plan[i]) begin
            total++;
            if (act_q[i] !== plan[i].c) begin
                bad++;
                $display("FAIL reset_mid_pre cyc%0d got=%h want=%h", i, act_q[i], plan[i].c);
            end
        end
        Reset = 1'b1; MemReady = 1'b1;
        exp = '0; exp.st = S_FETCH;
        @(negedge CLK);
        total++;
        if (sample() !== exp) begin
            bad++;
            $display("FAIL reset_mid_cycle got=%h want=%h", sample(), exp);
        end
        @(posedge CLK); #1;
        Reset = 1'b0; MemReady = 1'b0;
        @(negedge CLK);
        total++;
        if (sample() !== fetch_word(1'b0)) begin
            bad++;
            $display("FAIL reset_mid_after got=%h want=%h", sample(), fetch_word(1'b0));
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10];
        logic [5:0] op;
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI};
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            Opcode = op;
            plan.delete();
            plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            drive_plan();
            foreach (plan[i]) begin
                total++;
                if (act_q[i] !== plan[i].c || (act_q[i].mrd && act_q[i].mwr) ||
                    (act_q[i].pcw && act_q[i].pcwc)) begin
                    bad++;
                    $display("FAIL b2b op=%b cyc%0d got=%h want=%h", op, i, act_q[i], plan[i].c);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1; MemReady = 1'b0; Opcode = '0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_andi();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath.
- The datapath has one shared instruction/data memory, one ALU reused for PC increment, branch target and execute, plus IR, A/B and ALUOut holding registers.
- Replaces the single-cycle opcode decoder. Each instruction takes 3–5 states, with stalls on a memory ready handshake.
- Sits beside the datapath. Takes Opcode from the IR and MemReady from memory; drives all datapath mux selects and write enables.

Parameters:
- RESET_STATE, S_FETCH, initial state after reset.

Ports:
- CLK  input  1  clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- Opcode  input  6  IR[31:26]; stable from the cycle after FETCH completes
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- IorD  output  1  memory address: 0 PC, 1 ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  load IR from memory data
- ALUSrcA  output  1  0 PC, 1 A register
- ALUSrcB  output  2  00 B, 01 const 4, 10 imm-ext, 11 imm-ext<<2
- ALUop  output  4  to ALUControl, encoding from package
- SignExtend  output  1  1 sign, 0 zero extend imm16
- RegDst  output  1  1 rd, 0 rt
- MemToReg  output  1  1 MDR, 0 ALUOut
- RegWrite  output  1  register file write enable
- InstrDone  output  1  one-cycle pulse when an instruction retires
- IllegalOp  output  1  one-cycle pulse on unsupported opcode
- State  output  4  current state, for debug

Behaviour:
- Clocking and reset:
  - Single clock CLK, synchronous active-high Reset.
  - While Reset is high, every output is 0 and State = S_FETCH.
  - The first active FETCH is the cycle after Reset falls.
  - Reset mid-instruction abandons it immediately; no partial writes issue on the reset cycle.
- Outputs are decoded from state only, except the MemReady-gated enables noted below. Any output not listed for a state is 0.
- S_FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=ADD, PCSource=00.
  - IRWrite and PCWrite = MemReady.
  - Holds while MemReady=0; goes to S_DECODE on MemReady=1.
- S_DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUop=ADD, SignExtend=1.
  - Next state by Opcode:
    - LW/SW → S_MEMADR
    - RTYPE → S_EXEC
    - BEQ → S_BRANCH
    - J → S_JUMP
    - ADDI/ADDIU/ANDI/ORI/SLTI → S_IMMEXEC
    - any other opcode → S_FETCH, with IllegalOp=1 this cycle.
- S_MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=ADD, SignExtend=1. Goes to S_MEMRD for LW, S_MEMWR for SW.
- S_MEMRD: MemRead=1, IorD=1. Holds until MemReady, then S_MEMWB.
- S_MEMWB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone=1. Goes to S_FETCH.
- S_MEMWR:
  - MemWrite=1, IorD=1.
  - Holds until MemReady; InstrDone=MemReady.
  - Goes to S_FETCH on MemReady. MemWrite stays asserted for the whole stall.
- S_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=FUNC. Goes to S_RWB.
- S_RWB: RegWrite=1, RegDst=1, MemToReg=0, InstrDone=1. Goes to S_FETCH.
- S_BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=SUB, PCWriteCond=1, PCSource=01, InstrDone=1. Goes to S_FETCH.
- S_JUMP: PCWrite=1, PCSource=10, InstrDone=1. Goes to S_FETCH.
- S_IMMEXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUop: ADD for ADDI/ADDIU, AND for ANDI, OR for ORI, SLT for SLTI.
  - SignExtend=0 for ANDI/ORI, 1 otherwise.
  - Goes to S_IMMWB.
- S_IMMWB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1. Goes to S_FETCH.
- Latency (cycles, no stalls): LW 5; SW, R-type, immediate 4; BEQ, J 3. Each MemReady=0 cycle adds one.
- Any unreachable State encoding goes to S_FETCH on the next edge.
- Never asserted together: MemRead with MemWrite, or PCWrite with PCWriteCond.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_ADDI 001000, OP_ADDIU 001001, OP_SLTI 001010, OP_ANDI 001100, OP_ORI 001101)
  - ALUop encodings (ADD, SUB, AND, OR, SLT, FUNC), shared with ALUControl
  - the 4-bit state enum.
- Single module; no sub-module.

Test Plan:
- Reset=1 for 2 cycles, then 0, MemReady=1, Opcode=OP_LW → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemToReg=1 only in cycle 5; InstrDone single pulse in cycle 5.
- Opcode=OP_SW, MemReady held 0 for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles; InstrDone only on the MemReady=1 cycle; then FETCH.
- FETCH with MemReady=0 for 2 cycles, then 1 → IRWrite/PCWrite=0 during the stall, 1 only on the ready cycle; DECODE follows.
- Opcode=OP_ANDI → IMMEXEC with ALUop=AND, SignExtend=0, ALUSrcB=10; IMMWB with RegDst=0, RegWrite=1.
- Opcode=6'b111111 → IllegalOp=1 in the DECODE cycle, next state FETCH, no RegWrite/MemWrite/PCWrite asserted.
- Reset pulsed high during MEMRD stall → all outputs 0 that cycle; next cycle FETCH with MemRead=1.
